// File: rtl/lanzones_imem.sv
// Instruction memory responder for the lanzones core fetch port: program load, then fixed-latency fetches.
// Optional out-of-range fetch detection is enabled by defining LANZONES_IMEM_RANGE_CHECK_EN.
module lanzones_imem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RRdy,
  input  logic [31:0]   RAddr,
  output logic          RVld,
  output logic [31:0]   RData,
  output logic          LEn,
  input  logic          LdWe,
  input  logic [AW-1:0] LdAddr,
  input  logic [31:0]   LdData,
  input  logic          LdDone,
  output logic          Err,
  output logic [15:0]   FetchCnt
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  localparam logic [3:0]  LAT_M1 = 4'(LAT - 1);
  localparam logic [31:0] NOP    = 32'h00000013;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [AW-1:0] idx, idx_d;
  logic          oor, oor_d;
  logic          addr_hi;
  logic          fire;
  logic          mem_we;
  logic          len_d;
  logic [31:0]   mem [DEPTH];

`ifdef LANZONES_IMEM_RANGE_CHECK_EN
  assign addr_hi = |RAddr[31:AW];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |RAddr[31:AW];
  assign addr_hi        = 1'b0;
`endif

  // The response registers are loaded on the edge that enters RESP, so RVld is
  // high exactly while the FSM sits in RESP; WAIT fires when the count reaches 1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    oor_d   = oor;
    fire    = 1'b0;
    mem_we  = 1'b0;
    len_d   = LEn;
    unique case (state)
      S_LOAD: begin
        mem_we = LdWe & ~rst;
        if (LdDone) begin
          len_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (RRdy) begin
          idx_d = RAddr[AW-1:0];
          oor_d = addr_hi;
          if (LAT_M1 == 4'd0) begin
            fire = 1'b1;
          end else begin
            cnt_d   = LAT_M1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) fire = 1'b1;
        else             cnt_d = cnt - 4'd1;
      end
      S_RESP:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
    if (fire) state_d = S_RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      cnt      <= '0;
      idx      <= '0;
      oor      <= 1'b0;
      RVld     <= 1'b0;
      LEn      <= 1'b0;
      FetchCnt <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      oor   <= oor_d;
      RVld  <= fire;
      LEn   <= len_d;
      if (fire) FetchCnt <= FetchCnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       RData <= '0;
    else if (fire) RData <= oor_d ? NOP : mem[idx_d];
  end

  // Memory is never reset so a program image survives a core reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[LdAddr] <= LdData;
  end

`ifdef LANZONES_IMEM_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)               Err <= 1'b0;
    else if (fire && oor_d) Err <= 1'b1;
  end
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_lanzones_imem.sv
// Self-checking bench for lanzones_imem: three instances (LAT 1, 4, 8) share the load port.
// Expectations come from a word-array model of the program image plus sticky error and response counters.
module tb_lanzones_imem;

  localparam int NDUT = 3;
`ifdef LANZONES_IMEM_RANGE_CHECK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        rrdy  [NDUT];
  logic [31:0] raddr [NDUT];
  logic        rvld  [NDUT];
  logic [31:0] rdata [NDUT];
  logic        len   [NDUT];
  logic        err   [NDUT];
  logic [15:0] fcnt  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    lanzones_imem #(
      .DEPTH(1024),
      .AW(10),
      .LAT((g == 0) ? 1 : (g == 1) ? 4 : 8)
    ) dut (
      .clk(clk),
      .rst(rst),
      .RRdy(rrdy[g]),
      .RAddr(raddr[g]),
      .RVld(rvld[g]),
      .RData(rdata[g]),
      .LEn(len[g]),
      .LdWe(ld_we),
      .LdAddr(ld_addr),
      .LdData(ld_data),
      .LdDone(ld_done),
      .Err(err[g]),
      .FetchCnt(fcnt[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] img [1024];
  logic        err_m  [NDUT];
  int          fcnt_m [NDUT];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] alt;
    logic [31:0] exp;
    logic        exp_err;
    bit          hold;
  } vec_t;
  vec_t tbl [6];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 8;
  endfunction

  function automatic bit is_high(input logic [31:0] a);
    return a[31:10] != 22'd0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (RANGE && is_high(a)) return NOP;
    return img[a[9:0]];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Core-like requester: hold RRdy until RVld, optionally keep it high through RESP and GAP.
  task automatic do_fetch(input int k, input logic [31:0] addr, input logic [31:0] alt,
                          input bit hold, output logic [31:0] data, output int lat,
                          output bit extra);
    data  = '0;
    lat   = -1;
    extra = 1'b0;
    @(negedge clk);
    rrdy[k]  = 1'b1;
    raddr[k] = addr;
    for (int p = 1; p <= 40; p++) begin
      @(posedge clk);
      @(negedge clk);
      if (rvld[k]) begin
        lat  = p;
        data = rdata[k];
        break;
      end
      raddr[k] = alt;
    end
    if (!hold) rrdy[k] = 1'b0;
    for (int q = 0; q < 3; q++) begin
      @(posedge clk);
      @(negedge clk);
      if (rvld[k]) extra = 1'b1;
      if (q == 1) rrdy[k] = 1'b0;
    end
    rrdy[k] = 1'b0;
  endtask

  task automatic run_vec(input int k, input logic [31:0] addr, input logic [31:0] alt,
                         input bit hold, input logic [31:0] exp, input logic exp_err,
                         input string tag);
    logic [31:0] data;
    int          lat;
    bit          extra;
    do_fetch(k, addr, alt, hold, data, lat, extra);
    fcnt_m[k]++;
    check($sformatf("%s_data_d%0d", tag, k), data, exp);
    check($sformatf("%s_lat_d%0d", tag, k), lat, lat_of(k));
    check($sformatf("%s_extra_rvld_d%0d", tag, k), {31'd0, extra}, 32'd0);
    check($sformatf("%s_rdata_hold_d%0d", tag, k), rdata[k], exp);
    check($sformatf("%s_err_d%0d", tag, k), {31'd0, err[k]}, {31'd0, exp_err});
    check($sformatf("%s_fcnt_d%0d", tag, k), {16'd0, fcnt[k]}, 32'(fcnt_m[k] % 65536));
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_rvld_d%0d", tag, k), {31'd0, rvld[k]}, 32'd0);
      check($sformatf("%s_rdata_d%0d", tag, k), rdata[k], 32'd0);
      check($sformatf("%s_len_d%0d", tag, k), {31'd0, len[k]}, 32'd0);
      check($sformatf("%s_err_d%0d", tag, k), {31'd0, err[k]}, 32'd0);
      check($sformatf("%s_fcnt_d%0d", tag, k), {16'd0, fcnt[k]}, 32'd0);
    end
  endtask

  initial begin
    bit seen;

    img[0]    = 32'h123450B7;
    img[1]    = 32'h00001137;
    img[1023] = 32'hDEADBEEF;
    for (int i = 2; i < 1023; i++) img[i] = $urandom;

    tbl[0] = '{addr: 32'h0,   alt: 32'h0, exp: 32'h123450B7, exp_err: 1'b0,  hold: 1'b1};
    tbl[1] = '{addr: 32'h1,   alt: 32'h5, exp: 32'h00001137, exp_err: 1'b0,  hold: 1'b0};
    tbl[2] = '{addr: 32'h0,   alt: 32'h1, exp: 32'h123450B7, exp_err: 1'b0,  hold: 1'b1};
    tbl[3] = '{addr: 32'h3FF, alt: 32'h0, exp: 32'hDEADBEEF, exp_err: 1'b0,  hold: 1'b0};
    tbl[4] = '{addr: 32'h400, alt: 32'h7, exp: RANGE ? NOP : 32'h123450B7, exp_err: RANGE, hold: 1'b0};
    tbl[5] = '{addr: 32'h1,   alt: 32'h0, exp: 32'h00001137, exp_err: RANGE, hold: 1'b0};

    rst     = 1'b1;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    ld_done = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      rrdy[k]   = 1'b0;
      raddr[k]  = '0;
      err_m[k]  = 1'b0;
      fcnt_m[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Program load with fetch requests pending; no response may appear.
    seen = 1'b0;
    for (int k = 0; k < NDUT; k++) rrdy[k] = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (rvld[k]) seen = 1'b1;
      ld_we   = 1'b1;
      ld_addr = 10'(i);
      ld_data = img[i];
      ld_done = (i == 1023);
      if (i == 1023) for (int k = 0; k < NDUT; k++) rrdy[k] = 1'b0;
    end
    check("load_no_rvld", {31'd0, seen}, 32'd0);
    for (int k = 0; k < NDUT; k++) check($sformatf("len_before_done_d%0d", k), {31'd0, len[k]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    ld_we   = 1'b0;
    ld_done = 1'b0;
    for (int k = 0; k < NDUT; k++) check($sformatf("len_after_done_d%0d", k), {31'd0, len[k]}, 32'd1);

    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < NDUT; k++)
        run_vec(k, tbl[v].addr, tbl[v].alt, tbl[v].hold, tbl[v].exp, tbl[v].exp_err, $sformatf("tbl%0d", v));
    end

    // Writes after LEn must be ignored.
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = '0;
    ld_data = '0;
    ld_done = 1'b1;
    repeat (2) @(negedge clk);
    ld_we   = 1'b0;
    ld_done = 1'b0;

    for (int v = 2; v < 6; v++) begin
      for (int k = 0; k < NDUT; k++) begin
        run_vec(k, tbl[v].addr, tbl[v].alt, tbl[v].hold, tbl[v].exp, tbl[v].exp_err, $sformatf("tbl%0d", v));
        if (RANGE && is_high(tbl[v].addr)) err_m[k] = 1'b1;
      end
    end

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(1, 0) == 0) a[31:10] = '0;
        if (RANGE && is_high(a)) err_m[k] = 1'b1;
        repeat ($urandom_range(2, 0)) @(negedge clk);
        run_vec(k, a, $urandom, 1'($urandom_range(1, 0)), ref_word(a), err_m[k], "rnd");
      end
    end

    // Reset three cycles into a LAT=8 fetch: the response is discarded.
    seen = 1'b0;
    @(negedge clk);
    rrdy[2]  = 1'b1;
    raddr[2] = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rvld[2]) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (rvld[k]) seen = 1'b1;
    end
    check("rst_wait_no_rvld", {31'd0, seen}, 32'd0);
    check_reset_state("rst_wait");
    rrdy[2] = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      err_m[k]  = 1'b0;
      fcnt_m[k] = 0;
    end

    @(negedge clk);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    for (int k = 0; k < NDUT; k++) check($sformatf("reload_len_d%0d", k), {31'd0, len[k]}, 32'd1);
    for (int k = 0; k < NDUT; k++) begin
      run_vec(k, 32'h0, 32'h3, 1'b0, 32'h123450B7, 1'b0, "retain0");
      run_vec(k, 32'h1, 32'h0, 1'b1, 32'h00001137, 1'b0, "retain1");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
